tile_mem_arbiter: RTL

Arbitrates one single-port tile data RAM between the host-side CSR memory port (the AXI-Lite command path) and the RISC-V core's load/store port. It sits directly downstream of the tile's AXI register block: it consumes that block's `mem_*` request and returns read data into its `mem_dout`. It serialises host and core accesses onto one RAM with 1-cycle read latency, using round-robin fairness. It also reports host overruns.

---
 rtl/tile_mem_pkg.sv | 24 ++
 rtl/Register.sv | 21 ++
 rtl/tile_mem_rr_arb.sv | 35 +++
 rtl/tile_mem_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/tile_mem_pkg.sv
// Shared types and helpers for the tile data RAM arbiter.
package tile_mem_pkg;

    // Owner of the RAM access that is currently in its read-data cycle
    typedef enum logic [1:0] {
        NONE    = 2'd0,
        HOST_RD = 2'd1,
        HOST_WR = 2'd2,
        CORE    = 2'd3
    } owner_t;

    // Host writes always cover the full word
    localparam logic [3:0] BE_FULL = 4'hF;

    // Requester positions in the round-robin request/grant vectors
    localparam int unsigned REQ_HOST = 0;
    localparam int unsigned REQ_CORE = 1;

    // Byte address to word address; callers keep only the RAM's low bits
    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/Register.sv
// Generic D flop bank with synchronous active-high reset to a fixed value.
module Register #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset wins over the next-state value on the rising edge
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/tile_mem_rr_arb.sv
// Two-requester round-robin arbiter; the 'last' bit remembers who was served last.
module tile_mem_rr_arb
    import tile_mem_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    logic lastD;
    logic lastQ;

    // On a tie the requester that was not served last wins; 'last' moves only on a grant
    always_comb begin
        gnt   = req;
        lastD = lastQ;
        if (req == 2'b11) begin
            gnt = lastQ ? 2'b01 : 2'b10;
        end
        if (adv && (gnt != 2'b00)) begin
            lastD = gnt[REQ_CORE];
        end
    end

    // Reset to "core served last" so the host wins the first tie
    Register #(.WIDTH(1), .RESET_VALUE(1'b1)) lastReg (
        .clock (clock),
        .reset (reset),
        .d     (lastD),
        .q     (lastQ)
    );

endmodule

// File: rtl/tile_mem_arbiter.sv
// Shares one single-port tile RAM between the host CSR port and the core load/store port.
module tile_mem_arbiter
    import tile_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  host_strobe,
    input  logic                  host_en,
    input  logic                  host_we,
    input  logic [31:0]           host_addr,
    input  logic [DATA_WIDTH-1:0] host_din,
    output logic [DATA_WIDTH-1:0] host_dout,
    output logic                  host_ack,
    output logic                  host_busy,
    output logic                  host_overrun,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [3:0]            core_be,
    input  logic [31:0]           core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    if (DATA_WIDTH != 32) begin : gen_bad_data_width
        $error("tile_mem_arbiter: DATA_WIDTH must be 32");
    end

    logic                  pendD,     pendQ;
    logic                  pendWeD,   pendWeQ;
    logic [ADDR_WIDTH-1:0] pendAddrD, pendAddrQ;
    logic [DATA_WIDTH-1:0] pendDinD,  pendDinQ;
    logic                  overrunD,  overrunQ;
    logic [1:0]            tagD,      tagQRaw;
    logic [DATA_WIDTH-1:0] hostDoutD, hostDoutQ;
    owner_t                tagQ;

    logic [31:0]           hostWordFull;
    logic [31:0]           coreWordFull;
    logic [1:0]            arbReq;
    logic [1:0]            arbGnt;
    logic                  hostGrant;
    logic                  coreGrant;
    logic                  hostCapture;
    logic                  hostAccept;
    logic                  hostTag;
    logic                  unusedAddrBits;

    assign hostWordFull   = word_addr(host_addr);
    assign coreWordFull   = word_addr(core_addr);
    assign unusedAddrBits = ^{hostWordFull[31:ADDR_WIDTH], coreWordFull[31:ADDR_WIDTH]};

    assign tagQ = owner_t'(tagQRaw);

    // Nothing reaches the RAM while reset is held, so a reset cycle issues no access
    assign arbReq[REQ_HOST] = pendQ & ~Reset;
    assign arbReq[REQ_CORE] = core_req & ~Reset;

    tile_mem_rr_arb rrArb (
        .clock (Clock),
        .reset (Reset),
        .req   (arbReq),
        .adv   (~Reset),
        .gnt   (arbGnt)
    );

    assign hostGrant = arbGnt[REQ_HOST];
    assign coreGrant = arbGnt[REQ_CORE];

    // A new host command is taken if the slot is free or is being drained this very cycle
    assign hostCapture = host_strobe & host_en;
    assign hostAccept  = hostCapture & (~pendQ | hostGrant);

    // Next state for the pending host request, overrun flag and response owner tag
    always_comb begin
        pendD     = pendQ;
        pendWeD   = pendWeQ;
        pendAddrD = pendAddrQ;
        pendDinD  = pendDinQ;
        overrunD  = overrunQ;
        tagD      = NONE;
        if (hostGrant) begin
            pendD = 1'b0;
        end
        if (hostAccept) begin
            pendD     = 1'b1;
            pendWeD   = host_we;
            pendAddrD = hostWordFull[ADDR_WIDTH-1:0];
            pendDinD  = host_din;
        end else if (hostCapture) begin
            overrunD = 1'b1;
        end
        if (hostGrant) begin
            tagD = pendWeQ ? HOST_WR : HOST_RD;
        end else if (coreGrant) begin
            tagD = CORE;
        end
    end

    // Drive the RAM port from whichever requester holds the grant
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'h0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (hostGrant) begin
            ram_en    = 1'b1;
            ram_we    = pendWeQ ? BE_FULL : 4'h0;
            ram_addr  = pendAddrQ;
            ram_wdata = pendDinQ;
        end else if (coreGrant) begin
            ram_en    = 1'b1;
            ram_we    = core_we ? core_be : 4'h0;
            ram_addr  = coreWordFull[ADDR_WIDTH-1:0];
            ram_wdata = core_wdata;
        end
    end

    // A completing host read shows its data immediately and is then held
    assign hostDoutD = (tagQ == HOST_RD) ? ram_rdata : hostDoutQ;
    assign hostTag   = (tagQ == HOST_RD) || (tagQ == HOST_WR);

    Register #(.WIDTH(1))          pendReg     (.clock(Clock), .reset(Reset), .d(pendD),     .q(pendQ));
    Register #(.WIDTH(1))          pendWeReg   (.clock(Clock), .reset(Reset), .d(pendWeD),   .q(pendWeQ));
    Register #(.WIDTH(ADDR_WIDTH)) pendAddrReg (.clock(Clock), .reset(Reset), .d(pendAddrD), .q(pendAddrQ));
    Register #(.WIDTH(DATA_WIDTH)) pendDinReg  (.clock(Clock), .reset(Reset), .d(pendDinD),  .q(pendDinQ));
    Register #(.WIDTH(1))          overrunReg  (.clock(Clock), .reset(Reset), .d(overrunD),  .q(overrunQ));
    Register #(.WIDTH(2))          tagReg      (.clock(Clock), .reset(Reset), .d(tagD),      .q(tagQRaw));
    Register #(.WIDTH(DATA_WIDTH)) hostDoutReg (.clock(Clock), .reset(Reset), .d(hostDoutD), .q(hostDoutQ));

    // Responses are suppressed while reset is held so an in-flight access never completes
    assign core_gnt     = coreGrant;
    assign host_ack     = ~Reset & hostTag;
    assign host_busy    = ~Reset & (pendQ | hostTag);
    assign host_overrun = ~Reset & overrunQ;
    assign host_dout    = Reset ? '0 : hostDoutD;
    assign core_rvalid  = ~Reset & (tagQ == CORE);
    assign core_rdata   = core_rvalid ? ram_rdata : '0;

endmodule
